// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
//   Bundles the fetch handshake and the datapath control strobes of the
//   stack-machine sequencer.
//
//   master : the sequencer. Consumes instr/instr_valid and drives
//            instr_ready, isr and every control strobe.
//   slave  : instruction source plus datapath. Drives instr/instr_valid and
//            observes everything else.
//
//   Signals
//     instr        IW  instruction word from the instruction source
//     instr_valid   1  instr is valid this cycle
//     instr_ready   1  sequencer accepts instr this cycle
//     isr          IW  instruction register, to the datapath
//     regw          1  register-bank write enable
//     sflag         1  status-flag update enable
//     memw          1  stack memory write enable
//     memin         2  memory data select: 0 reg x, 1 PC, 2 sign-extended offset
//     spi           2  SP control: 0 hold, 1 +1, 2 -1
//     pcin          1  PC source: 0 memory top, 1 increment path
//     pci           1  increment path: 0 PC+1, 1 PC+1+offset when cc
//     pcw           1  PC load enable
//     done          1  pulse on the final cycle of each instruction
//     halted        1  high while halted
// ---------------------------------------------------------------------------
interface cpu_sequencer_if #(
  parameter int IW = 16
);
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] isr;
  logic          regw;
  logic          sflag;
  logic          memw;
  logic [1:0]    memin;
  logic [1:0]    spi;
  logic          pcin;
  logic          pci;
  logic          pcw;
  logic          done;
  logic          halted;

  modport master (
    input  instr, instr_valid,
    output instr_ready, isr, regw, sflag, memw, memin, spi,
           pcin, pci, pcw, done, halted
  );

  modport slave (
    output instr, instr_valid,
    input  instr_ready, isr, regw, sflag, memw, memin, spi,
           pcin, pci, pcw, done, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control unit for the 16-bit stack-machine datapath. Accepts
//   one instruction at a time over a valid/ready handshake, latches it in the
//   instruction register (isr) and walks it through a small FSM that emits
//   the datapath strobes. The stack lives in memory addressed only by SP and
//   grows downward, so a push decrements SP one cycle before the write.
//
//   Ports
//     clk    in   rising-edge clock
//     reset  in   synchronous, active-high reset
//     bus    master modport of cpu_sequencer_if (handshake, isr, strobes)
//
//   Opcode layout (top nibble of isr)
//     [15:14] class : 00 ALU, 01 stack, 10 control, 11 branch
//     [13:12] sub   : stack   00 PUSHR 01 PUSHI 10 POP 11 NOP
//                     control 00 NOP   01 CALL  10 RET 11 HALT
//   The low OFFW bits carry the branch/immediate offset; the datapath does
//   the sign extension and the cc evaluation, the sequencer never looks at
//   the offset itself.
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int IW   = 16,
  parameter int OFFW = 12
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);

  // The class/sub nibble must sit above the offset field.
  if (IW < 4 || OFFW > IW - 4) begin : g_bad_field_layout
    $error("cpu_sequencer: OFFW=%0d does not fit below the opcode nibble of IW=%0d", OFFW, IW);
  end

  typedef enum logic [3:0] {
    S_FETCH,
    S_EXEC,
    S_PUSH_DEC,
    S_PUSH_WR,
    S_CALL_DEC,
    S_CALL_WR,
    S_RET_LD,
    S_RET_POP,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       ready;
    logic       regw;
    logic       sflag;
    logic       memw;
    logic [1:0] memin;
    logic [1:0] spi;
    logic       pcin;
    logic       pci;
    logic       pcw;
    logic       done;
    logic       halted;
  } ctrl_t;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_STK = 2'b01;
  localparam logic [1:0] CLS_CTL = 2'b10;
  localparam logic [1:0] CLS_BR  = 2'b11;

  localparam logic [1:0] STK_PUSHR = 2'b00;
  localparam logic [1:0] STK_PUSHI = 2'b01;
  localparam logic [1:0] STK_POP   = 2'b10;

  localparam logic [1:0] CTL_CALL = 2'b01;
  localparam logic [1:0] CTL_RET  = 2'b10;
  localparam logic [1:0] CTL_HALT = 2'b11;

  localparam logic [1:0] SP_HOLD = 2'd0;
  localparam logic [1:0] SP_INC  = 2'd1;
  localparam logic [1:0] SP_DEC  = 2'd2;

  localparam logic [1:0] MEMIN_REG = 2'd0;
  localparam logic [1:0] MEMIN_PC  = 2'd1;
  localparam logic [1:0] MEMIN_OFF = 2'd2;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] ir;
  logic [IW-1:0] ir_n;
  ctrl_t         ctrl;

  // First state after FETCH, chosen from the freshly accepted opcode nibble.
  function automatic state_t dispatch(input logic [3:0] op);
    state_t s;
    s = S_EXEC;
    case (op[3:2])
      CLS_STK: begin
        if (op[1:0] == STK_PUSHR || op[1:0] == STK_PUSHI) s = S_PUSH_DEC;
      end
      CLS_CTL: begin
        case (op[1:0])
          CTL_CALL: s = S_CALL_DEC;
          CTL_RET:  s = S_RET_LD;
          CTL_HALT: s = S_HALT;
          default:  s = S_EXEC;
        endcase
      end
      default: s = S_EXEC;
    endcase
    return s;
  endfunction

  // Strobes for a given state and opcode nibble; anything not set stays 0.
  function automatic ctrl_t decode(input state_t s, input logic [3:0] op);
    ctrl_t c;
    c       = '0;
    c.spi   = SP_HOLD;
    c.memin = MEMIN_REG;
    case (s)
      S_FETCH: c.ready = 1'b1;

      S_EXEC: begin
        c.done = 1'b1;
        c.pcw  = 1'b1;
        c.pcin = 1'b1;
        case (op[3:2])
          CLS_ALU: begin
            c.regw  = 1'b1;
            c.sflag = 1'b1;
          end
          CLS_STK: begin
            if (op[1:0] == STK_POP) c.spi = SP_INC;
          end
          // Relative jump; the datapath forces cc for this class.
          CLS_BR:  c.pci = 1'b1;
          default: ;
        endcase
      end

      // SP moves first so the write lands in the new top slot.
      S_PUSH_DEC: c.spi = SP_DEC;

      S_PUSH_WR: begin
        c.memw  = 1'b1;
        c.memin = (op[1:0] == STK_PUSHI) ? MEMIN_OFF : MEMIN_REG;
        c.pcw   = 1'b1;
        c.pcin  = 1'b1;
        c.done  = 1'b1;
      end

      S_CALL_DEC: c.spi = SP_DEC;

      // PC still holds the CALL address here, which is what gets stacked,
      // while the same edge loads the branch target.
      S_CALL_WR: begin
        c.memw  = 1'b1;
        c.memin = MEMIN_PC;
        c.pcw   = 1'b1;
        c.pcin  = 1'b1;
        c.pci   = 1'b1;
        c.done  = 1'b1;
      end

      // Restore the stacked CALL address, then step past it while popping.
      S_RET_LD: c.pcw = 1'b1;

      S_RET_POP: begin
        c.spi  = SP_INC;
        c.pcw  = 1'b1;
        c.pcin = 1'b1;
        c.done = 1'b1;
      end

      S_HALT:  c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_n = state;
    ir_n    = ir;
    case (state)
      S_FETCH: begin
        if (bus.instr_valid) begin
          ir_n    = bus.instr;
          state_n = dispatch(bus.instr[IW-1 -: 4]);
        end
      end
      S_EXEC:     state_n = S_FETCH;
      S_PUSH_DEC: state_n = S_PUSH_WR;
      S_PUSH_WR:  state_n = S_FETCH;
      S_CALL_DEC: state_n = S_CALL_WR;
      S_CALL_WR:  state_n = S_FETCH;
      S_RET_LD:   state_n = S_RET_POP;
      S_RET_POP:  state_n = S_FETCH;
      S_HALT:     state_n = S_HALT;
      default:    state_n = S_FETCH;
    endcase
  end

  // Strobes are registered from the next state and next IR, so each output
  // is a pure function of the current (state, IR) pair without any
  // combinational path from the handshake inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
      ctrl  <= decode(S_FETCH, 4'h0);
    end else begin
      state <= state_n;
      ir    <= ir_n;
      ctrl  <= decode(state_n, ir_n[IW-1 -: 4]);
    end
  end

  assign bus.instr_ready = ctrl.ready;
  assign bus.isr         = ir;
  assign bus.regw        = ctrl.regw;
  assign bus.sflag       = ctrl.sflag;
  assign bus.memw        = ctrl.memw;
  assign bus.memin       = ctrl.memin;
  assign bus.spi         = ctrl.spi;
  assign bus.pcin        = ctrl.pcin;
  assign bus.pci         = ctrl.pci;
  assign bus.pcw         = ctrl.pcw;
  assign bus.done        = ctrl.done;
  assign bus.halted      = ctrl.halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//   Directed bench for cpu_sequencer. Each issued instruction queues the
//   strobe vectors it should produce cycle by cycle; the queue is drained and
//   compared as the sequencer runs. A small behavioural datapath (PC, SP,
//   stack memory) follows the strobes so PC/SP/memory effects are checked too.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.IW(16)) bus ();

  cpu_sequencer #(.IW(16), .OFFW(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {ready, regw, sflag, memw, memin[1:0], spi[1:0], pcin, pci, pcw, done, halted}
  logic [14:0] obs_vec;
  assign obs_vec = {bus.instr_ready, bus.regw, bus.sflag, bus.memw, bus.memin,
                    bus.spi, bus.pcin, bus.pci, bus.pcw, bus.done, bus.halted};

  // Behavioural datapath model
  localparam logic [15:0] REGX = 16'h1234;
  logic [15:0] pc;
  logic [7:0]  sp;
  logic [15:0] mem [256];
  logic [15:0] sext;
  logic        cc;
  assign sext = {{4{bus.isr[11]}}, bus.isr[11:0]};
  assign cc   = (bus.isr[15:12] >= 4'd9);

  always @(posedge clk) begin
    if (reset) begin
      pc <= 16'h0000;
      sp <= 8'h00;
    end else begin
      if (bus.memw)
        mem[sp] <= (bus.memin == 2'd1) ? pc : (bus.memin == 2'd2) ? sext : REGX;
      if (bus.pcw)
        pc <= !bus.pcin ? mem[sp] : (bus.pci && cc) ? pc + 16'd1 + sext : pc + 16'd1;
      if (bus.spi == 2'd1) sp <= sp + 8'd1;
      else if (bus.spi == 2'd2) sp <= sp - 8'd1;
    end
  end

  // Scoreboard
  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [14:0] F;  // idle FETCH
  logic [14:0] H;  // halted

  function automatic logic [14:0] cv(input int rdy, input int regw, input int sflag,
                                     input int memw, input int memin, input int spi,
                                     input int pcin, input int pci, input int pcw,
                                     input int done, input int halted);
    return {rdy[0], regw[0], sflag[0], memw[0], memin[1:0], spi[1:0],
            pcin[0], pci[0], pcw[0], done[0], halted[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_cyc(input string tag, input logic [14:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic run_one();
    exp_t e;
    if (q.size() == 0) begin
      check("queue_underrun", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check(e.tag, obs_vec, e.v);
      tick();
    end
  endtask

  task automatic run_all();
    while (q.size() > 0) run_one();
  endtask

  // Present a word in FETCH, accept it on the next edge, then scribble on
  // instr so any late sampling would corrupt isr.
  task automatic issue(input string tag, input logic [15:0] w);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    check({tag, "_fetch"}, obs_vec, F);
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = ~w;
    check({tag, "_isr"}, bus.isr, w);
  endtask

  initial begin
    F = cv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    H = cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset           = 1'b1;
    bus.instr       = 16'h0000;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset_vec", obs_vec, F);
    check("reset_isr", bus.isr, 16'h0000);

    // ALU funsel 2, r2
    issue("alu", 16'h1200);
    expect_cyc("alu_exec", cv(0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0));
    run_all();
    check("alu_back_fetch", obs_vec, F);
    check("alu_pc", pc, 16'h0001);

    // PUSHI -1
    issue("pushi", 16'h5FFF);
    expect_cyc("pushi_dec", cv(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    expect_cyc("pushi_wr",  cv(0, 0, 0, 1, 2, 0, 1, 0, 1, 1, 0));
    run_all();
    check("pushi_top", mem[8'hFF], 16'hFFFF);
    check("pushi_sp", sp, 8'hFF);
    check("pushi_pc", pc, 16'h0002);

    // BR +13 -> PC 0x0010
    issue("br", 16'hC00D);
    expect_cyc("br_exec", cv(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    run_all();
    check("br_pc", pc, 16'h0010);

    // CALL +5 from 0x0010
    issue("call", 16'h9005);
    expect_cyc("call_dec", cv(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    expect_cyc("call_wr",  cv(0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0));
    run_all();
    check("call_pc", pc, 16'h0016);
    check("call_sp", sp, 8'hFE);
    check("call_stacked", mem[8'hFE], 16'h0010);

    // RET
    issue("ret", 16'hA000);
    expect_cyc("ret_ld",  cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    expect_cyc("ret_pop", cv(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
    run_one();
    check("ret_ld_pc", pc, 16'h0010);
    run_one();
    check("ret_pc", pc, 16'h0011);
    check("ret_sp", sp, 8'hFF);

    // Idle FETCH with a changing but invalid instr
    for (int i = 0; i < 5; i++) begin
      bus.instr = 16'h1200 + 16'(i);
      check("idle_vec", obs_vec, F);
      check("idle_isr", bus.isr, 16'hA000);
      check("idle_pc", pc, 16'h0011);
      tick();
    end

    // POP
    issue("pop", 16'h6000);
    expect_cyc("pop_exec", cv(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
    run_all();
    check("pop_sp", sp, 8'h00);
    check("pop_pc", pc, 16'h0012);
    check("pop_isr_held", bus.isr, 16'h6000);

    // PUSHR r3
    issue("pushr", 16'h4300);
    expect_cyc("pushr_dec", cv(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    expect_cyc("pushr_wr",  cv(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0));
    run_all();
    check("pushr_top", mem[8'hFF], REGX);
    check("pushr_pc", pc, 16'h0013);

    // Control-class NOP
    issue("ctlnop", 16'h8000);
    expect_cyc("ctlnop_exec", cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    run_all();
    check("ctlnop_pc", pc, 16'h0014);

    // Reset during CALL_WR
    issue("call2", 16'h9003);
    expect_cyc("call2_dec", cv(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    run_one();
    check("call2_wr", obs_vec, cv(0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0));
    reset = 1'b1;
    tick();
    check("midreset_vec", obs_vec, F);
    check("midreset_isr", bus.isr, 16'h0000);
    reset = 1'b0;

    // HALT holds under continuous valid stimulus
    issue("halt", 16'hB000);
    bus.instr       = 16'h1200;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("halt_vec", obs_vec, H);
      check("halt_isr", bus.isr, 16'hB000);
      tick();
    end
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_reset_vec", obs_vec, F);
    check("halt_reset_isr", bus.isr, 16'h0000);

    check("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control unit that drives the 16-bit stack-machine datapath.
- Accepts instruction words over a valid/ready fetch handshake and holds the current word in an instruction register, presented to the datapath as isr.
- Sequences each instruction through an FSM and produces the datapath control strobes: regw, memw, memin, sflag, spi, pcin, pci, plus a PC write enable pcw.
- Memory is addressed only by SP; the stack grows downward.

Parameters:
- IW, 16, instruction/isr width.
- OFFW, 12, branch/immediate offset field width; the datapath sign-extends isr[OFFW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  IW  instruction word from instruction source.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  sequencer accepts instr this cycle.
- isr  out  IW  instruction register, to datapath.
- regw  out  1  register-bank write enable.
- sflag  out  1  status-flag update enable.
- memw  out  1  stack memory write enable.
- memin  out  2  memory data select: 0 = reg x, 1 = PC, 2 = sign-extended offset.
- spi  out  2  SP control: 0 = hold, 1 = +1, 2 = -1.
- pcin  out  1  PC source: 0 = memory top (y), 1 = increment path.
- pci  out  1  increment path: 0 = PC+1, 1 = PC+1+offset when cc.
- pcw  out  1  PC load enable; PC holds when 0.
- done  out  1  one-cycle pulse on the final cycle of each instruction.
- halted  out  1  high in HALT state.

Behaviour:
- Decode from IR: class = isr[15:14], sub = isr[13:12].
- Class 00, ALU: funsel is isr[13:11], dest/src register is isr[10:8].
- Class 01, stack sub-ops: 00 PUSHR, 01 PUSHI, 10 POP, 11 NOP.
- Class 10, control sub-ops: 00 NOP, 01 CALL, 10 RET, 11 HALT.
- Class 11, BR: unconditional relative jump. isr[15:12] >= 9 forces cc = 1 in the datapath.
- States: FETCH, EXEC, PUSH_DEC, PUSH_WR, CALL_DEC, CALL_WR, RET_LD, RET_POP, HALT.
- All outputs are decoded combinationally from state and IR. Any strobe not listed for a state is 0; spi = 0 and memin = 0 by default.
- FETCH:
  - instr_ready = 1.
  - On instr_valid: IR <= instr, next state from decode. PUSHR/PUSHI -> PUSH_DEC; CALL -> CALL_DEC; RET -> RET_LD; HALT -> HALT; all others -> EXEC.
  - No valid: stay in FETCH, IR unchanged.
- EXEC (1 cycle), then FETCH. done = 1, pcw = 1, pcin = 1.
  - ALU: regw = 1, sflag = 1, pci = 0.
  - POP: spi = 1, pci = 0.
  - NOPs: pci = 0.
  - BR: pci = 1.
- PUSH_DEC: spi = 2. Next PUSH_WR.
- PUSH_WR: memw = 1, memin = 0 (PUSHR) or 2 (PUSHI). pcw = 1, pcin = 1, pci = 0, done = 1. Next FETCH.
- CALL_DEC: spi = 2. Next CALL_WR.
- CALL_WR: memw = 1, memin = 1 (stores PC of the CALL). pcw = 1, pcin = 1, pci = 1 (target = PC+1+offset). done = 1. Next FETCH.
- RET_LD: pcw = 1, pcin = 0 (PC <= stored CALL PC). Next RET_POP.
- RET_POP: spi = 1, pcw = 1, pcin = 1, pci = 0 (PC <= CALL PC + 1), done = 1. Next FETCH.
- HALT: halted = 1, all strobes 0, instr_ready = 0. Left only by reset.
- Latency from accept to done:
  - ALU, POP, NOP, BR: 1 cycle.
  - PUSHR, PUSHI, CALL, RET: 2 cycles.
- Throughput: one instruction per 2 cycles minimum, since FETCH is never overlapped with execution.
- Reset:
  - Takes effect at the next clock edge regardless of state, including mid-PUSH/CALL/RET.
  - State <= FETCH, IR <= 0.
  - All strobes are 0 and halted = 0 from that cycle on; the partial operation is abandoned (e.g. SP already decremented).
- instr is sampled only when instr_valid && instr_ready. Changes on instr outside FETCH are ignored.
- pcw = 0 in FETCH, PUSH_DEC and CALL_DEC; PC never moves in those cycles.
- Reserved/NOP encodings still advance PC by 1.

Test Plan:
- Reset, then present 0x1200 (ALU funsel 2, r2) with valid -> instr_ready = 1 in cycle 0; next cycle regw = 1, sflag = 1, pcw = 1, pcin = 1, pci = 0, done = 1; then back to FETCH.
- PUSHI 0x5FFF (offset 0xFFF = -1) -> PUSH_DEC spi = 2, then PUSH_WR memw = 1, memin = 2, done = 1; datapath stack top = 0xFFFF, SP = maxmem-1.
- CALL 0x9005 at PC = 0x0010, then RET 0xA000 -> mem[SP] = 0x0010, PC = 0x0016. RET gives PC = 0x0010 then 0x0011, and SP is restored to its pre-CALL value.
- instr_valid low for 5 cycles in FETCH -> instr_ready stays 1, pcw/regw/memw stay 0, IR unchanged, done = 0.
- Assert reset during CALL_WR -> next cycle state = FETCH, memw = 0, pcw = 0, isr = 0x0000.
- HALT 0xB000 -> halted = 1 and instr_ready = 0 indefinitely under valid stimulus; reset -> halted = 0, instr_ready = 1.
